gray_div3_pipe: RTL and testbench

- Pipelined RGB-to-grayscale stage that consumes 24-bit pixels and produces 8-bit gray = average of R, G, B.
- Each channel is divided by 3 with the team's multiply-by-reciprocal arithmetic, and the three quotients are summed.
- Sits between the pixel source (camera/frame reader) and the display/threshold stages.
- Adds valid/ready flow control and a per-frame pixel counter.

---
 rtl/gray_div3_pipe_pkg.sv | 13 +
 rtl/gray_div3_pipe_div3.sv | 12 +
 rtl/gray_div3_pipe.sv | 117 +++++++++++
 tb/tb_gray_div3_pipe.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/gray_div3_pipe_pkg.sv
// Shared constants for the RGB-to-gray divide-by-3 pipeline.
package gray_div3_pipe_pkg;
  localparam int CH_W       = 8;
  localparam int Q_W        = 7;
  localparam int PROD_W     = 24;
  localparam int DIV3_MUL   = 21849;
  localparam int DIV3_SHIFT = 16;
  localparam int SIDE_SOF   = 0;
  localparam int SIDE_EOL   = 1;

  typedef logic [CH_W-1:0] chan_t;
  typedef logic [Q_W-1:0]  quot_t;
endpackage

// File: rtl/gray_div3_pipe_div3.sv
// Divide an 8-bit channel by 3 using multiply-by-reciprocal; exact for 0..255.
module gray_div3_pipe_div3
  import gray_div3_pipe_pkg::*;
(
  input  chan_t i_x,
  output quot_t o_q
);
  logic [PROD_W-1:0] w_prod;

  assign w_prod = PROD_W'(i_x) * PROD_W'(DIV3_MUL);
  assign o_q    = Q_W'(w_prod >> DIV3_SHIFT);
endmodule

// File: rtl/gray_div3_pipe.sv
// Two-stage RGB-to-gray averager with valid/ready flow control and per-frame pixel count.
// Define GRAY_DIV3_ROUND_EN to fold the channel remainders back in for an exact (R+G+B)/3.
module gray_div3_pipe
  import gray_div3_pipe_pkg::*;
#(
  parameter int SIDE_W = 2,
  parameter int CNT_W  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [23:0]       in_rgb,
  input  logic [SIDE_W-1:0] in_side,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_gray,
  output logic [SIDE_W-1:0] out_side,
  output logic [CNT_W-1:0]  pix_cnt
);
  logic                  w_s2_adv;
  logic                  w_s1_adv;
  logic                  w_in_acc;
  logic [2:0][Q_W-1:0]   w_q;
  logic [CH_W-1:0]       w_sum;

  logic [2:0][Q_W-1:0]   r_q;
  logic [SIDE_W-1:0]     r_side;
  logic                  r_s1_valid;
  logic                  r_out_valid;
  logic [CH_W-1:0]       r_out_gray;
  logic [SIDE_W-1:0]     r_out_side;
  logic [CNT_W-1:0]      r_pix_cnt;

  // Ready chains back from the output so a full pipe still accepts while draining.
  assign w_s2_adv = !r_out_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign w_in_acc = in_valid && w_s1_adv;

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_ch
      gray_div3_pipe_div3 u_div3 (
        .i_x (in_rgb[gi*CH_W +: CH_W]),
        .o_q (w_q[gi])
      );
    end
  endgenerate

`ifdef GRAY_DIV3_ROUND_EN
  logic [2:0][1:0] w_rem;
  logic [2:0]      w_rs;
  logic [2:0]      r_rs;
  logic [1:0]      w_corr;

  generate
    for (gi = 0; gi < 3; gi++) begin : g_rem
      assign w_rem[gi] = 2'(in_rgb[gi*CH_W +: CH_W] - CH_W'(CH_W'(w_q[gi]) * CH_W'(3)));
    end
  endgenerate

  assign w_rs   = 3'(w_rem[0]) + 3'(w_rem[1]) + 3'(w_rem[2]);
  assign w_corr = {1'b0, (r_rs >= 3'd3)} + {1'b0, (r_rs >= 3'd6)};
  assign w_sum  = CH_W'(r_q[0]) + CH_W'(r_q[1]) + CH_W'(r_q[2]) + CH_W'(w_corr);

  always_ff @(posedge clk) begin
    if (w_in_acc) begin
      r_rs <= w_rs;
    end
  end
`else
  assign w_sum = CH_W'(r_q[0]) + CH_W'(r_q[1]) + CH_W'(r_q[2]);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
    end else if (w_s1_adv) begin
      r_s1_valid <= w_in_acc;
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_acc) begin
      r_q    <= w_q;
      r_side <= in_side;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_gray  <= '0;
      r_out_side  <= '0;
    end else if (w_s2_adv) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_gray <= w_sum;
        r_out_side <= r_side;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pix_cnt <= '0;
    end else if (w_in_acc) begin
      r_pix_cnt <= in_side[SIDE_SOF] ? CNT_W'(1) : r_pix_cnt + CNT_W'(1);
    end
  end

  assign in_ready  = w_s1_adv;
  assign out_valid = r_out_valid;
  assign out_gray  = r_out_gray;
  assign out_side  = r_out_side;
  assign pix_cnt   = r_pix_cnt;
endmodule

// File: tb/tb_gray_div3_pipe.sv
// Scoreboard bench for gray_div3_pipe; follows GRAY_DIV3_ROUND_EN for its reference model.
module tb_gray_div3_pipe;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] in_rgb;
  logic [1:0]  in_side;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_gray;
  logic [1:0]  out_side;
  logic [19:0] pix_cnt;

  logic        in_ready4;
  logic        out_valid4;
  logic [7:0]  out_gray4;
  logic [1:0]  out_side4;
  logic [3:0]  pix_cnt4;

  int          checks = 0;
  int          errors = 0;
  int          n_acc  = 0;
  logic        last_acc;
  logic [9:0]  sb[$];

  gray_div3_pipe #(.SIDE_W(2), .CNT_W(20)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_rgb(in_rgb), .in_side(in_side), .out_valid(out_valid),
    .out_ready(out_ready), .out_gray(out_gray), .out_side(out_side),
    .pix_cnt(pix_cnt)
  );

  // Narrow-counter copy on the same stimulus, used only for the wrap check.
  gray_div3_pipe #(.SIDE_W(2), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_rgb(in_rgb), .in_side(in_side), .out_valid(out_valid4),
    .out_ready(out_ready), .out_gray(out_gray4), .out_side(out_side4),
    .pix_cnt(pix_cnt4)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model_gray(input logic [23:0] rgb);
    int r, g, b;
    r = int'(rgb[23:16]);
    g = int'(rgb[15:8]);
    b = int'(rgb[7:0]);
`ifdef GRAY_DIV3_ROUND_EN
    return 8'((r + g + b) / 3);
`else
    return 8'(r / 3 + g / 3 + b / 3);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: observe handshakes at the falling edge, then step past the rising edge.
  task automatic cycle();
    logic [9:0] e;
    @(negedge clk);
    last_acc = in_valid && in_ready;
    if (last_acc) begin
      sb.push_back({in_side, model_gray(in_rgb)});
      n_acc++;
    end
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("no_extra_out", 32'(out_valid), 32'd0);
      end else begin
        e = sb.pop_front();
        check("stream", 32'({out_side, out_gray}), 32'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [23:0] rgb, input logic [1:0] side);
    int waited;
    in_valid = 1'b1;
    in_rgb   = rgb;
    in_side  = side;
    waited   = 0;
    do begin
      cycle();
      waited++;
    end while (!last_acc && waited < 100);
    if (!last_acc) check("send_timeout", 32'(last_acc), 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int waited;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    waited    = 0;
    while (sb.size() != 0 && waited < 50) begin
      cycle();
      waited++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic one_pix(input string tag, input logic [23:0] rgb, input logic [7:0] exp_gray);
    int waited;
    drain();
    send(rgb, 2'b00);
    waited = 0;
    while (!out_valid && waited < 10) begin
      cycle();
      waited++;
    end
    check({tag, "_latency"}, 32'(waited), 32'd1);
    check(tag, 32'(out_gray), 32'(exp_gray));
    drain();
  endtask

  initial begin
    logic [7:0] held;
    int guard;
    int start;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_rgb = '0; in_side = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_gray", 32'(out_gray), 32'd0);
    check("rst_pix_cnt", 32'(pix_cnt), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Every value of each channel in turn, streamed back to back.
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      for (int x = 0; x < 256; x++) begin
        send(24'(x) << (8 * c), 2'(x));
      end
    end
    drain();

    one_pix("r255", 24'hFF0000, 8'd85);
    one_pix("b254", 24'h0000FE, 8'd84);
`ifdef GRAY_DIV3_ROUND_EN
    one_pix("rgb111", {8'd1, 8'd1, 8'd1}, 8'd1);
    one_pix("rgb100_50_0", {8'd100, 8'd50, 8'd0}, 8'd50);
`else
    one_pix("rgb111", {8'd1, 8'd1, 8'd1}, 8'd0);
    one_pix("rgb100_50_0", {8'd100, 8'd50, 8'd0}, 8'd49);
`endif
    one_pix("rgb255", 24'hFFFFFF, 8'd255);

    // Backpressure: two pixels fill the pipe, the third must wait.
    out_ready = 1'b0;
    start = n_acc;
    in_valid = 1'b1;
    in_rgb = {8'd30, 8'd60, 8'd90};  in_side = 2'b01; cycle();
    in_rgb = {8'd10, 8'd20, 8'd200}; in_side = 2'b10; cycle();
    in_rgb = {8'd7, 8'd8, 8'd9};     in_side = 2'b00;
    held = model_gray({8'd30, 8'd60, 8'd90});
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_gray_hold", 32'(out_gray), 32'(held));
    end
    check("bp_accepts", 32'(n_acc - start), 32'd2);
    out_ready = 1'b1;
    guard = 0;
    while (!last_acc && guard < 20) begin
      cycle();
      guard++;
    end
    in_valid = 1'b0;
    check("bp_third_accepted", 32'(n_acc - start), 32'd3);
    drain();

    // Per-frame counter and the 4-bit wrap.
    send(24'h112233, 2'b01);
    for (int i = 0; i < 9; i++) send(24'(i * 5), 2'b00);
    drain();
    check("pix_cnt_10", 32'(pix_cnt), 32'd10);
    send(24'h445566, 2'b01);
    check("pix_cnt_sof", 32'(pix_cnt), 32'd1);
    for (int i = 0; i < 14; i++) send(24'(i * 7), 2'b00);
    check("pix_cnt4_15", 32'(pix_cnt4), 32'd15);
    send(24'h010203, 2'b10);
    check("pix_cnt4_wrap", 32'(pix_cnt4), 32'd0);
    check("pix_cnt_16", 32'(pix_cnt), 32'd16);
    drain();

    // Random valid/ready traffic checked in order by the scoreboard.
    start = n_acc;
    guard = 0;
    while ((n_acc - start) < 10000 && guard < 60000) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_rgb    = 24'($urandom());
      in_side   = 2'($urandom_range(0, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
      guard++;
    end
    check("random_count", 32'(n_acc - start), 32'd10000);
    drain();

    // Reset with two pixels in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_rgb = 24'hABCDEF; in_side = 2'b01; cycle();
    in_rgb = 24'h123456; in_side = 2'b00; cycle();
    in_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    sb.delete();
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_gray", 32'(out_gray), 32'd0);
    check("mid_rst_pix_cnt", 32'(pix_cnt), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (5) cycle();
    send(24'h0F0F0F, 2'b01);
    drain();
    check("post_rst_pix_cnt", 32'(pix_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
